// File: rtl/picosoc_memio.sv
// picosoc_memio: PicoRV32 native-bus RAM/GPIO slave with bus-error response and CPU reset stretcher
module picosoc_memio #(
  parameter int MEM_WORDS = 256,
  parameter MEM_INIT_FILE = "",
  parameter int WAIT_STATES = 0,
  parameter int GPIO_WIDTH = 8,
  parameter logic [31:0] GPIO_ADDR = 32'h1000_0000,
  parameter logic [GPIO_WIDTH-1:0] GPIO_INIT = '0,
  parameter int RESET_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  cpu_resetn,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_wdata,
  input  logic [3:0]            mem_wstrb,
  output logic [31:0]           mem_rdata,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  bus_err,
  output logic                  bus_err_sticky
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [29:0] GO_W = GPIO_ADDR[31:2];
  localparam logic [29:0] GI_W = GO_W + 30'd1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] rst_cnt;
  logic [3:0] wcnt;
  logic [29:0] a_word;
  logic [31:0] a_wdata;
  logic [3:0] a_wstrb;
  logic [GPIO_WIDTH-1:0] gin_meta, gin_sync, g_new;
  logic [31:0] mem [MEM_WORDS];
  logic start, acc, wr, is_ram, is_gout, is_gin, unmapped;
  logic [AW-1:0] ram_idx;
  logic [1:0] unused_addr;
  assign unused_addr = mem_addr[1:0];
  assign start = cpu_resetn && mem_valid && !mem_ready;
  assign acc = state == RESP;
  assign wr = |a_wstrb;
  assign is_ram = {2'b0, a_word} < 32'(MEM_WORDS);
  assign is_gout = !is_ram && a_word == GO_W;
  assign is_gin = !is_ram && !is_gout && a_word == GI_W;
  assign unmapped = !(is_ram || is_gout || is_gin);
  assign ram_idx = a_word[AW-1:0];
  always_comb begin
    g_new = gpio_out;
    for (int b = 0; b < GPIO_WIDTH; b++) g_new[b] = a_wstrb[b/8] ? a_wdata[b] : gpio_out[b];
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (start ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE) :
              (state == WAIT) ? (wcnt == 4'(WAIT_STATES - 1) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    wcnt <= (state == WAIT && !reset) ? wcnt + 4'd1 : 4'd0;
    if (state == IDLE && start) begin
      a_word <= mem_addr[31:2];
      a_wdata <= mem_wdata;
      a_wstrb <= mem_wstrb;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      rst_cnt <= '0;
      cpu_resetn <= 1'b0;
    end else if (!cpu_resetn) begin
      rst_cnt <= rst_cnt + 1'b1;
      cpu_resetn <= rst_cnt == CW'(RESET_CYCLES - 1);
    end
  always_ff @(posedge clk)
    if (reset) {gin_sync, gin_meta} <= '0;
    else {gin_sync, gin_meta} <= {gin_meta, gpio_in};
  always_ff @(posedge clk)
    if (reset) begin
      mem_ready <= 1'b0;
      bus_err <= 1'b0;
      bus_err_sticky <= 1'b0;
      mem_rdata <= '0;
      gpio_out <= GPIO_INIT;
    end else begin
      mem_ready <= acc;
      bus_err <= acc && unmapped;
      bus_err_sticky <= bus_err_sticky || (acc && unmapped);
      if (acc && !wr)
        mem_rdata <= is_ram ? mem[ram_idx] : is_gout ? 32'(gpio_out) : is_gin ? 32'(gin_sync) : 32'd0;
      if (acc && wr && is_gout) gpio_out <= g_new;
    end
  always_ff @(posedge clk)
    if (!reset && acc && wr && is_ram)
      for (int i = 0; i < 4; i++)
        if (a_wstrb[i]) mem[ram_idx][8*i +: 8] <= a_wdata[8*i +: 8];
endmodule

// File: tb/tb_picosoc_memio.sv
// tb_picosoc_memio: directed scoreboard bench for picosoc_memio with zero and three wait states
module tb_picosoc_memio;
  localparam logic [31:0] GA = 32'h1000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] cpu_resetn, mem_valid, mem_ready, bus_err, bus_err_sticky;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0] mem_wstrb;
  logic [1:0][7:0] gpio_out;
  logic [7:0] gpio_in;
  logic [31:0] last_rd [2];
  int n_assert = 0;
  int n_fail = 0;
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;

  picosoc_memio #(.MEM_WORDS(64), .WAIT_STATES(0), .GPIO_WIDTH(8), .GPIO_INIT(8'h5A), .RESET_CYCLES(4)) u0 (
    .clk(clk), .reset(reset), .cpu_resetn(cpu_resetn[0]), .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]), .mem_rdata(mem_rdata[0]),
    .gpio_out(gpio_out[0]), .gpio_in(gpio_in), .bus_err(bus_err[0]), .bus_err_sticky(bus_err_sticky[0]));
  picosoc_memio #(.MEM_WORDS(64), .WAIT_STATES(3), .GPIO_WIDTH(8), .GPIO_INIT(8'h5A), .RESET_CYCLES(4)) u3 (
    .clk(clk), .reset(reset), .cpu_resetn(cpu_resetn[1]), .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]), .mem_rdata(mem_rdata[1]),
    .gpio_out(gpio_out[1]), .gpio_in(gpio_in), .bus_err(bus_err[1]), .bus_err_sticky(bus_err_sticky[1]));

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one bus transfer: expectation goes into the scoreboard at issue, is popped at mem_ready
  task automatic access(int d, logic [31:0] a, logic [31:0] wd, logic [3:0] ws, logic [31:0] er, logic ee, string tag);
    exp_t e, g;
    int k;
    if (ws == 4'd0) last_rd[d] = er;
    e.rdata = last_rd[d];
    e.err = ee;
    e.lat = d ? 4 : 1;
    sb.push_back(e);
    @(negedge clk);
    mem_addr[d] = a;
    mem_wdata[d] = wd;
    mem_wstrb[d] = ws;
    mem_valid[d] = 1'b1;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!mem_ready[d] && k < 20);
    mem_valid[d] = 1'b0;
    g = sb.pop_front();
    chk({tag, " ready"}, 32'(mem_ready[d]), 32'd1);
    chk({tag, " latency"}, 32'(k - 1), 32'(g.lat));
    chk({tag, " bus_err"}, 32'(bus_err[d]), 32'(g.err));
    chk({tag, " rdata"}, mem_rdata[d], g.rdata);
    @(posedge clk);
    #1;
    chk({tag, " single pulse"}, 32'(mem_ready[d]), 32'd0);
  endtask

  initial begin
    logic seen;
    mem_valid = '0;
    mem_addr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    gpio_in = 8'h00;
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset cpu_resetn", 32'(cpu_resetn[d]), 32'd0);
      chk("reset mem_ready", 32'(mem_ready[d]), 32'd0);
      chk("reset gpio_out", 32'(gpio_out[d]), 32'h5A);
      chk("reset rdata", mem_rdata[d], 32'd0);
      chk("reset sticky", 32'(bus_err_sticky[d]), 32'd0);
    end
    // release reset with an early request pending on u0
    @(negedge clk);
    reset = 1'b0;
    mem_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      seen = seen | mem_ready[0];
      chk("stretch u0", 32'(cpu_resetn[0]), 32'(i == 4));
      chk("stretch u3", 32'(cpu_resetn[1]), 32'(i == 4));
      if (i == 3) mem_valid[0] = 1'b0;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | mem_ready[0];
    end
    chk("early request ignored", 32'(seen), 32'd0);
    // RAM byte strobes, zero wait states
    access(0, 32'h8, 32'hAABBCCDD, 4'hF, 32'h0, 1'b0, "t2 w full");
    access(0, 32'h8, 32'h11223344, 4'b0101, 32'h0, 1'b0, "t2 w strobe");
    access(0, 32'h8, 32'h0, 4'h0, 32'hAA22CC44, 1'b0, "t2 rd");
    access(0, 32'hB, 32'h0, 4'h0, 32'hAA22CC44, 1'b0, "t2 rd lowbits");
    access(0, 32'hFC, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, "t2 w last");
    access(0, 32'hFC, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, "t2 rd last");
    chk("sticky clear", 32'(bus_err_sticky[0]), 32'd0);
    access(0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1, "t2 past ram");
    // GPIO_OUT with three wait states
    access(1, GA, 32'h000000A5, 4'hF, 32'h0, 1'b0, "t3 w gpio");
    chk("t3 gpio_out", 32'(gpio_out[1]), 32'hA5);
    access(1, GA, 32'h0, 4'h0, 32'h000000A5, 1'b0, "t3 rd gpio");
    access(1, GA, 32'h0000FF00, 4'b0010, 32'h0, 1'b0, "t3 w lane1");
    chk("t3 lane1 no effect", 32'(gpio_out[1]), 32'hA5);
    access(1, GA, 32'hFFFFFF0F, 4'b0001, 32'h0, 1'b0, "t3 w lane0");
    chk("t3 lane0", 32'(gpio_out[1]), 32'h0F);
    // GPIO_IN through the synchroniser
    gpio_in = 8'h3C;
    repeat (2) @(posedge clk);
    access(1, GA + 32'd4, 32'h0, 4'h0, 32'h0000003C, 1'b0, "t4 rd gpio_in");
    access(1, GA + 32'd4, 32'h000000FF, 4'hF, 32'h0, 1'b0, "t4 w gpio_in");
    chk("t4 gpio_out kept", 32'(gpio_out[1]), 32'h0F);
    chk("t4 u3 sticky", 32'(bus_err_sticky[1]), 32'd0);
    // unmapped access
    access(0, 32'h8, 32'h0, 4'h0, 32'hAA22CC44, 1'b0, "t5 rd ram");
    access(0, 32'h2000_0000, 32'h0, 4'h0, 32'h0, 1'b1, "t5 rd unmapped");
    chk("t5 sticky", 32'(bus_err_sticky[0]), 32'd1);
    access(0, 32'h8, 32'h0, 4'h0, 32'hAA22CC44, 1'b0, "t5 rd after");
    chk("t5 sticky held", 32'(bus_err_sticky[0]), 32'd1);
    // reset during the wait phase of a RAM write
    access(1, 32'h8, 32'h12345678, 4'hF, 32'h0, 1'b0, "t6 w");
    access(1, 32'h8, 32'h0, 4'h0, 32'h12345678, 1'b0, "t6 rd");
    @(negedge clk);
    mem_addr[1] = 32'h8;
    mem_wdata[1] = 32'hFFFFFFFF;
    mem_wstrb[1] = 4'hF;
    mem_valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mem_valid[1] = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      seen = seen | mem_ready[1];
    end
    chk("t6 no ready", 32'(seen), 32'd0);
    chk("t6 gpio_out init", 32'(gpio_out[1]), 32'h5A);
    chk("t6 sticky cleared", 32'(bus_err_sticky[0]), 32'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6 stretch low", 32'(cpu_resetn[1]), 32'd0);
    @(posedge clk);
    #1;
    chk("t6 stretch high", 32'(cpu_resetn[1]), 32'd1);
    access(1, 32'h8, 32'h0, 4'h0, 32'h12345678, 1'b0, "t6 ram kept");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
